pwm_peripheral: RTL and testbench
=================================

PWM_PERIPHERAL -- requirements
Module: pwm_peripheral

Interface
REQ-001 SHALL have parameter CLK_DIV, default 13, meaning clk cycles per PWM counter step (legal 1..65535).
REQ-002 SHALL have port clk  input  1  single system clock; all state on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port en_reg_out_7_0  input  8  output enable for out[7:0].
REQ-005 SHALL have port en_reg_out_15_8  input  8  output enable for out[15:8].
REQ-006 SHALL have port en_reg_pwm_7_0  input  8  PWM-mode select for out[7:0].
REQ-007 SHALL have port en_reg_pwm_15_8  input  8  PWM-mode select for out[15:8].
REQ-008 SHALL have port pwm_duty_cycle  input  8  requested duty; 0x00 = 0%, 0xFF = 100%.
REQ-009 SHALL have port out  output  16  driven pins; [7:0] feeds uo_out, [15:8] feeds uio_out.
REQ-010 SHALL have port period_tick  output  1  one-cycle pulse marking PWM period start.
REQ-011 SHALL treat all inputs as synchronous to clk; no CDC inside this block.

Function
REQ-012 SHALL contain a prescaler counting 0..CLK_DIV-1, wrapping to 0; step = prescaler == CLK_DIV-1.
REQ-013 SHALL contain an 8-bit pwm_counter incrementing by 1 on each step, wrapping 255 -> 0.
REQ-014 SHALL have a period of exactly 256*CLK_DIV clk cycles.
REQ-015 SHALL define period start as prescaler == 0 and pwm_counter == 0.
REQ-016 SHALL load duty_shadow <= pwm_duty_cycle on the clock edge ending each period-start cycle, and at no other time.
REQ-017 SHALL ignore pwm_duty_cycle changes mid-period; the new value takes effect at the next period start.
REQ-018 SHALL compute pwm_level = 1 when duty_shadow == 0xFF, else (pwm_counter < duty_shadow), unsigned 8-bit compare.
REQ-019 SHALL yield 0x00 -> constant low and 0xFF -> constant high, with no one-step glitch in either case.
REQ-020 SHALL compute next out[i] = en_out[i] ? (en_pwm[i] ? pwm_level : 1) : 0, where en_out = {en_reg_out_15_8, en_reg_out_7_0} and en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0}.
REQ-021 SHALL register out, giving 1 clk latency from any enable change to a change on out.
REQ-022 SHALL apply enable changes immediately (next edge), not at the period boundary.
REQ-023 SHALL assert period_tick, registered, for exactly one cycle: the cycle after each duty_shadow load.
REQ-024 SHALL with CLK_DIV == 1 step pwm_counter on every clk edge and hold prescaler at 0.

Reset
REQ-025 SHALL on rst_n low asynchronously clear prescaler, pwm_counter, duty_shadow, out (16'h0000) and period_tick (0).
REQ-026 SHALL treat the first cycle after rst_n deassertion as a period start (load shadow, pulse period_tick next cycle).
REQ-027 SHALL, on reset mid-period, discard the partial period with no residual state.

Structure
REQ-028 SHALL place PWM_WIDTH (8), NUM_OUTPUTS (16) and DEFAULT_CLK_DIV (13) in shared package pwm_pkg.
REQ-029 SHALL implement the prescaler, pwm_counter and period-start detection in sub-module pwm_timebase, exposing pwm_counter and period_start.
REQ-030 SHALL keep the shadow register, compare and output muxing in pwm_peripheral.

Verification
REQ-031 SHALL cover: CLK_DIV=13, all enables 0xFF, duty 0x80 -> each out bit high 1664 cycles, low 1664 cycles, per 3328-cycle period.
REQ-032 SHALL cover: duty 0x00 then 0xFF, PWM enabled -> out constant 0 for a full period, then constant 1, with no glitch cycle.
REQ-033 SHALL cover: en_reg_out_7_0=0x0F, en_reg_pwm_7_0=0x05, duty 0x40 -> out[7:4]=0, out[3] and out[1] constant 1, out[2] and out[0] PWM at 25%.
REQ-034 SHALL cover: duty changed 0x20 -> 0xC0 at pwm_counter 100 -> current period keeps 0x20 waveform; the next period after period_tick uses 0xC0.
REQ-035 SHALL cover: rst_n pulsed low mid-period with duty 0x80 -> out=0 and period_tick=0 asynchronously; after release the first period_tick occurs 2 cycles later and the waveform restarts at count 0.
REQ-036 SHALL cover: CLK_DIV=1, duty 0x01 -> out high exactly 1 cycle per 256-cycle period, period_tick every 256 cycles.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared constants for the PWM peripheral: counter width, output count and default divider.
package pwm_pkg;

  localparam int PWM_WIDTH       = 8;
  localparam int NUM_OUTPUTS     = 16;
  localparam int DEFAULT_CLK_DIV = 13;

  localparam logic [PWM_WIDTH-1:0] DUTY_FULL = '1;

endpackage

// File: rtl/pwm_timebase.sv
// PWM timebase: prescaler dividing clk by CLK_DIV, 8-bit PWM counter and period-start detect.
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic [PWM_WIDTH-1:0] pwm_counter,
  output logic                 period_start
);

  localparam int              PRE_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);

  logic [PRE_W-1:0] prescaler;
  logic             step;

  // With CLK_DIV == 1 PRE_LAST is 0, so step is constant and prescaler never leaves 0.
  assign step = (prescaler == PRE_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler   <= '0;
      pwm_counter <= '0;
    end else if (step) begin
      prescaler   <= '0;
      pwm_counter <= pwm_counter + 1'b1;
    end else begin
      prescaler   <= prescaler + 1'b1;
    end
  end

  assign period_start = (prescaler == '0) && (pwm_counter == '0);

endmodule

// File: rtl/pwm_peripheral.sv
// 16-output PWM peripheral: per-period duty shadow, compare and registered per-pin output muxing.
module pwm_peripheral
  import pwm_pkg::*;
#(
  parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] out,
  output logic        period_tick
);

  logic [PWM_WIDTH-1:0]   pwm_counter;
  logic [PWM_WIDTH-1:0]   duty_shadow;
  logic                   period_start;
  logic                   pwm_level;
  logic [NUM_OUTPUTS-1:0] en_out;
  logic [NUM_OUTPUTS-1:0] en_pwm;
  logic [NUM_OUTPUTS-1:0] out_next;

  // Full scale is forced high so 0xFF never drops low on the last counter step.
  function automatic logic pwm_compare(input logic [PWM_WIDTH-1:0] count,
                                       input logic [PWM_WIDTH-1:0] duty);
    return (duty == DUTY_FULL) || (count < duty);
  endfunction

  pwm_timebase #(
    .CLK_DIV(CLK_DIV)
  ) u_timebase (
    .clk         (clk),
    .rst_n       (rst_n),
    .pwm_counter (pwm_counter),
    .period_start(period_start)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_shadow <= '0;
    end else if (period_start) begin
      duty_shadow <= pwm_duty_cycle;
    end
  end

  assign en_out    = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm    = {en_reg_pwm_15_8, en_reg_pwm_7_0};
  assign pwm_level = pwm_compare(pwm_counter, duty_shadow);

  always_comb begin
    out_next = en_out & (~en_pwm | {NUM_OUTPUTS{pwm_level}});
  end

  // Output stage: pins and period pulse are registered one cycle after the compare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out         <= '0;
      period_tick <= 1'b0;
    end else begin
      out         <= out_next;
      period_tick <= period_start;
    end
  end

endmodule

// File: tb/tb_pwm_peripheral.sv
// Directed bench for pwm_peripheral: vector table on a CLK_DIV=13 instance plus multi-cycle sequences.
module tb_pwm_peripheral;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  en_reg_out_7_0  = 8'h00;
  logic [7:0]  en_reg_out_15_8 = 8'h00;
  logic [7:0]  en_reg_pwm_7_0  = 8'h00;
  logic [7:0]  en_reg_pwm_15_8 = 8'h00;
  logic [7:0]  pwm_duty_cycle  = 8'h00;
  logic [15:0] out13, out1;
  logic        tick13, tick1;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  always #5 clk = ~clk;

  pwm_peripheral #(.CLK_DIV(13)) dut13 (
    .clk            (clk),
    .rst_n          (rst_n),
    .en_reg_out_7_0 (en_reg_out_7_0),
    .en_reg_out_15_8(en_reg_out_15_8),
    .en_reg_pwm_7_0 (en_reg_pwm_7_0),
    .en_reg_pwm_15_8(en_reg_pwm_15_8),
    .pwm_duty_cycle (pwm_duty_cycle),
    .out            (out13),
    .period_tick    (tick13)
  );

  pwm_peripheral #(.CLK_DIV(1)) dut1 (
    .clk            (clk),
    .rst_n          (rst_n),
    .en_reg_out_7_0 (en_reg_out_7_0),
    .en_reg_out_15_8(en_reg_out_15_8),
    .en_reg_pwm_7_0 (en_reg_pwm_7_0),
    .en_reg_pwm_15_8(en_reg_pwm_15_8),
    .pwm_duty_cycle (pwm_duty_cycle),
    .out            (out1),
    .period_tick    (tick1)
  );

  typedef struct packed {
    logic [15:0] en_out;
    logic [15:0] en_pwm;
    logic [7:0]  duty;
    int          n;
    logic [15:0] exp_out;
    logic        exp_tick;
  } vec_t;

  vec_t tbl[$];

  task automatic set_inputs(input logic [15:0] eo, input logic [15:0] ep, input logic [7:0] d);
    {en_reg_out_15_8, en_reg_out_7_0} = eo;
    {en_reg_pwm_15_8, en_reg_pwm_7_0} = ep;
    pwm_duty_cycle = d;
  endtask

  // Edge n (counted from 1 after release) ends cycle n-1; sampling happens on the next negedge.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, got, exp, cyc);
    end
  endtask

  initial begin
    int hi, lo, other, bad, ticks;

    tbl.push_back('{16'hFFFF, 16'hFFFF, 8'h80,    1, 16'h0000, 1'b1});
    tbl.push_back('{16'hFFFF, 16'hFFFF, 8'h80,    2, 16'hFFFF, 1'b0});
    tbl.push_back('{16'hFFFF, 16'hFFFF, 8'h80, 1664, 16'hFFFF, 1'b0});
    tbl.push_back('{16'hFFFF, 16'hFFFF, 8'h80, 1665, 16'h0000, 1'b0});
    tbl.push_back('{16'hFFFF, 16'hFFFF, 8'h80, 3328, 16'h0000, 1'b0});
    tbl.push_back('{16'hFFFF, 16'hFFFF, 8'h80, 3329, 16'hFFFF, 1'b1});
    tbl.push_back('{16'h000F, 16'h0005, 8'h40,    2, 16'h000F, 1'b0});
    tbl.push_back('{16'h000F, 16'h0005, 8'h40,  832, 16'h000F, 1'b0});
    tbl.push_back('{16'h000F, 16'h0005, 8'h40,  833, 16'h000A, 1'b0});
    tbl.push_back('{16'hFF00, 16'h0000, 8'h00,    1, 16'hFF00, 1'b1});
    tbl.push_back('{16'h0000, 16'hFFFF, 8'hFF,    5, 16'h0000, 1'b0});
    tbl.push_back('{16'hFFFF, 16'hFFFF, 8'hFF,    2, 16'hFFFF, 1'b0});
    tbl.push_back('{16'hFFFF, 16'hFFFF, 8'hFF, 3328, 16'hFFFF, 1'b0});
    tbl.push_back('{16'hFFFF, 16'hFFFF, 8'hFF, 3329, 16'hFFFF, 1'b1});
    tbl.push_back('{16'hFFFF, 16'hFFFF, 8'h00,    2, 16'h0000, 1'b0});
    tbl.push_back('{16'hFFFF, 16'hFFFF, 8'h00,   14, 16'h0000, 1'b0});
    tbl.push_back('{16'hFFFF, 16'hFFFF, 8'h01,   13, 16'hFFFF, 1'b0});
    tbl.push_back('{16'hFFFF, 16'hFFFF, 8'h01,   14, 16'h0000, 1'b0});
    tbl.push_back('{16'hA5C3, 16'h0F0F, 8'h10,  100, 16'hA5C3, 1'b0});
    tbl.push_back('{16'hA5C3, 16'h0F0F, 8'h10,  300, 16'hA0C0, 1'b0});

    // Reset state
    set_inputs(16'hFFFF, 16'hFFFF, 8'h80);
    @(negedge clk);
    check("reset out13", out13, 16'h0000);
    check("reset tick13", tick13, 1'b0);
    check("reset out1", out1, 16'h0000);

    for (int i = 0; i < tbl.size(); i++) begin
      if (i == 0 || tbl[i].en_out != tbl[i-1].en_out || tbl[i].en_pwm != tbl[i-1].en_pwm ||
          tbl[i].duty != tbl[i-1].duty || tbl[i].n < cyc) begin
        set_inputs(tbl[i].en_out, tbl[i].en_pwm, tbl[i].duty);
        do_reset();
      end
      while (cyc < tbl[i].n) step();
      check($sformatf("vec%0d out", i), out13, tbl[i].exp_out);
      check($sformatf("vec%0d tick", i), tick13, tbl[i].exp_tick);
    end

    // 50% duty: 1664 high / 1664 low cycles over one full period
    set_inputs(16'hFFFF, 16'hFFFF, 8'h80);
    do_reset();
    step();
    hi = 0; lo = 0; other = 0;
    while (cyc < 3329) begin
      step();
      if (out13 == 16'hFFFF) hi++;
      else if (out13 == 16'h0000) lo++;
      else other++;
    end
    check("half duty high count", hi, 1664);
    check("half duty low count", lo, 1664);
    check("half duty split bits", other, 0);

    // 0x00 for a period, then 0xFF requested mid-period: no glitch either way
    set_inputs(16'hFFFF, 16'hFFFF, 8'h00);
    do_reset();
    step();
    bad = 0; ticks = 0;
    while (cyc < 6657) begin
      step();
      if (cyc == 2000) pwm_duty_cycle = 8'hFF;
      if (tick13) ticks++;
      if (cyc <= 3329 && out13 != 16'h0000) bad++;
      if (cyc > 3329 && out13 != 16'hFFFF) bad++;
    end
    check("zero-to-full glitch cycles", bad, 0);
    check("zero-to-full ticks", ticks, 2);

    // Duty change mid-period takes effect only at the next period start
    set_inputs(16'hFFFF, 16'hFFFF, 8'h20);
    do_reset();
    while (cyc < 416) step();
    check("duty20 last high", out13, 16'hFFFF);
    step();
    check("duty20 first low", out13, 16'h0000);
    while (cyc < 1300) step();
    pwm_duty_cycle = 8'hC0;
    while (cyc < 1400) step();
    check("duty change ignored mid-period", out13, 16'h0000);
    while (cyc < 3329) step();
    check("duty change tick", tick13, 1'b1);
    check("duty change period start out", out13, 16'hFFFF);
    while (cyc < 3746) step();
    check("new duty in effect", out13, 16'hFFFF);
    while (cyc < 5824) step();
    check("dutyC0 last high", out13, 16'hFFFF);
    step();
    check("dutyC0 first low", out13, 16'h0000);

    // Enable changes apply on the next edge; then async reset mid-period
    set_inputs(16'hFFFF, 16'hFFFF, 8'h80);
    do_reset();
    while (cyc < 400) step();
    set_inputs(16'h0000, 16'hFFFF, 8'h80);
    step();
    check("enable off immediate", out13, 16'h0000);
    set_inputs(16'hFFFF, 16'h0000, 8'h80);
    step();
    check("enable on non-pwm immediate", out13, 16'hFFFF);
    set_inputs(16'hFFFF, 16'hFFFF, 8'h80);
    while (cyc < 500) step();
    check("pre-reset out", out13, 16'hFFFF);
    #2 rst_n = 1'b0;
    #1;
    check("async reset out", out13, 16'h0000);
    check("async reset tick", tick13, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    step();
    check("post-reset first tick", tick13, 1'b1);
    step();
    check("post-reset tick cleared", tick13, 1'b0);
    check("post-reset restart out", out13, 16'hFFFF);
    while (cyc < 1664) step();
    check("post-reset last high", out13, 16'hFFFF);
    step();
    check("post-reset first low", out13, 16'h0000);

    // CLK_DIV=1 instance, duty 0x01: one high cycle and one tick per 256 cycles
    set_inputs(16'hFFFF, 16'hFFFF, 8'h01);
    do_reset();
    step();
    check("div1 first tick", tick1, 1'b1);
    check("div1 first out", out1, 16'h0000);
    hi = 0; ticks = 0; other = 0;
    while (cyc < 513) begin
      step();
      if (cyc == 257) begin
        check("div1 tick at 256", tick1, 1'b1);
        check("div1 high at period start", out1, 16'hFFFF);
      end
      if (tick1) ticks++;
      if (out1 == 16'hFFFF) hi++;
      else if (out1 != 16'h0000) other++;
    end
    check("div1 high count", hi, 2);
    check("div1 tick count", ticks, 2);
    check("div1 split bits", other, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
